// File: rtl/locker_access_ctrl.sv
// Digital locker access controller: code entry, compare, door/wrong/lockout phases.
// Define LOCKER_ENTRY_TIMEOUT_EN to abort an idle code entry as a wrong attempt.
module locker_access_ctrl #(
    parameter int unsigned CODE_LEN    = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYC    = 200,
    parameter int unsigned BUZZ_CYC    = 50,
    parameter int unsigned LOCKOUT_CYC = 1000,
    parameter int unsigned TIMEOUT_CYC = 500
) (
    input  logic                           clock,
    input  logic                           clear_n,
    input  logic [1:0]                     bn,
    input  logic                           bn_valid,
    input  logic [2*CODE_LEN-1:0]          sw,
    input  logic                           relock,
    output logic                           door_open,
    output logic                           led_right,
    output logic                           led_wrong,
    output logic                           buzzer,
    output logic                           locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries,
    output logic [2:0]                     state
);

    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned IDX_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned SYM_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned MAX_AB  = (OPEN_CYC > BUZZ_CYC) ? OPEN_CYC : BUZZ_CYC;
    localparam int unsigned MAX_CD  = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_WRONG   = 3'd4,
        S_LOCKOUT = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mis_q, mis_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         code_q [CODE_LEN];
    logic [1:0]         code_d [CODE_LEN];
    logic               door_q, right_q, wrong_q, buzz_q, lock_q;
    logic [1:0]         cur_sym;

    assign cur_sym = code_q[SYM_W'(idx_q)];

    // Next-state, counter and code-register logic
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        timer_d = timer_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (bn_valid) begin
                    for (int i = 0; i < int'(CODE_LEN); i++) begin
                        code_d[i] = sw[2*i +: 2];
                    end
                    idx_d   = IDX_W'(1);
                    mis_d   = (bn != sw[1:0]);
                    timer_d = TIMER_W'(TIMEOUT_CYC - 1);
                    state_d = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (bn_valid) begin
                    mis_d   = mis_q | (bn != cur_sym);
                    idx_d   = idx_q + IDX_W'(1);
                    timer_d = TIMER_W'(TIMEOUT_CYC - 1);
                    if (idx_d == IDX_W'(CODE_LEN)) begin
                        state_d = S_CHECK;
                    end
                end
`ifdef LOCKER_ENTRY_TIMEOUT_EN
                else if (timer_q == '0) begin
                    mis_d   = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
`endif
            end
            S_CHECK: begin
                if (!mis_q) begin
                    tries_d = '0;
                    timer_d = TIMER_W'(OPEN_CYC - 1);
                    state_d = S_OPEN;
                end else begin
                    tries_d = (tries_q == TRIES_W'(MAX_TRIES)) ? tries_q : tries_q + TRIES_W'(1);
                    if (tries_d == TRIES_W'(MAX_TRIES)) begin
                        timer_d = TIMER_W'(LOCKOUT_CYC - 1);
                        state_d = S_LOCKOUT;
                    end else begin
                        timer_d = TIMER_W'(BUZZ_CYC - 1);
                        state_d = S_WRONG;
                    end
                end
            end
            S_OPEN: begin
                if (relock || timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_WRONG: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    tries_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and Moore outputs decoded from the next state
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            tries_q <= '0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            timer_q <= '0;
            code_q  <= '{default: '0};
            door_q  <= 1'b0;
            right_q <= 1'b0;
            wrong_q <= 1'b0;
            buzz_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            door_q  <= (state_d == S_OPEN);
            right_q <= (state_d == S_OPEN);
            wrong_q <= (state_d == S_WRONG) || (state_d == S_LOCKOUT);
            buzz_q  <= (state_d == S_WRONG) || (state_d == S_LOCKOUT);
            lock_q  <= (state_d == S_LOCKOUT);
        end
    end

    assign door_open  = door_q;
    assign led_right  = right_q;
    assign led_wrong  = wrong_q;
    assign buzzer     = buzz_q;
    assign locked_out = lock_q;
    assign tries      = tries_q;
    assign state      = 3'(state_q);

endmodule

// File: tb/tb_locker_access_ctrl.sv
// Bench for locker_access_ctrl: directed scenarios plus randomized episodes
// checked every cycle against a deadline-based behavioural model.
module tb_locker_access_ctrl;

    localparam int unsigned CODE_LEN    = 4;
    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned OPEN_CYC    = 200;
    localparam int unsigned BUZZ_CYC    = 50;
    localparam int unsigned LOCKOUT_CYC = 1000;
    localparam int unsigned TIMEOUT_CYC = 500;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic [1:0] bn = 2'd0;
    logic       bn_valid = 1'b0;
    logic [7:0] sw = 8'hE4;
    logic       relock = 1'b0;
    logic       door_open, led_right, led_wrong, buzzer, locked_out;
    logic [1:0] tries;
    logic [2:0] state;

    locker_access_ctrl dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .bn         (bn),
        .bn_valid   (bn_valid),
        .sw         (sw),
        .relock     (relock),
        .door_open  (door_open),
        .led_right  (led_right),
        .led_wrong  (led_wrong),
        .buzzer     (buzzer),
        .locked_out (locked_out),
        .tries      (tries),
        .state      (state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: phase number, entered-symbol queue, absolute phase deadlines
    int         m_st = 0;
    int         m_tries = 0;
    int         m_cyc = 0;
    int         m_end = 0;
    int         m_last = 0;
    bit         m_forced = 0;
    bit         m_ok;
    logic [1:0] m_code [CODE_LEN];
    logic [1:0] m_got [$];

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_st = 0; m_tries = 0; m_forced = 0; m_got.delete();
        end else begin
            m_cyc++;
            case (m_st)
                0: if (bn_valid) begin
                    for (int i = 0; i < int'(CODE_LEN); i++) m_code[i] = sw[2*i +: 2];
                    m_got.delete();
                    m_got.push_back(bn);
                    m_forced = 0;
                    m_last = m_cyc;
                    m_st = (m_got.size() == int'(CODE_LEN)) ? 2 : 1;
                end
                1: if (bn_valid) begin
                    m_got.push_back(bn);
                    m_last = m_cyc;
                    if (m_got.size() == int'(CODE_LEN)) m_st = 2;
                end
`ifdef LOCKER_ENTRY_TIMEOUT_EN
                else if (m_cyc - m_last >= int'(TIMEOUT_CYC)) begin
                    m_forced = 1;
                    m_st = 2;
                end
`endif
                2: begin
                    m_ok = !m_forced;
                    for (int i = 0; i < int'(CODE_LEN); i++)
                        if (i >= m_got.size() || m_got[i] != m_code[i]) m_ok = 0;
                    if (m_ok) begin
                        m_tries = 0; m_st = 3; m_end = m_cyc + int'(OPEN_CYC);
                    end else begin
                        if (m_tries < int'(MAX_TRIES)) m_tries++;
                        if (m_tries == int'(MAX_TRIES)) begin
                            m_st = 5; m_end = m_cyc + int'(LOCKOUT_CYC);
                        end else begin
                            m_st = 4; m_end = m_cyc + int'(BUZZ_CYC);
                        end
                    end
                end
                3: if (relock || m_cyc >= m_end) m_st = 0;
                4: if (m_cyc >= m_end) m_st = 0;
                5: if (m_cyc >= m_end) begin m_st = 0; m_tries = 0; end
                default: m_st = 0;
            endcase
        end
    end

    function automatic logic [4:0] exp_leds();
        return {m_st == 3, m_st == 3, m_st == 4 || m_st == 5, m_st == 4 || m_st == 5, m_st == 5};
    endfunction

    task automatic check_outputs();
        check("leds", 32'({door_open, led_right, led_wrong, buzzer, locked_out}), 32'(exp_leds()));
        check("tries", 32'(tries), 32'(m_tries));
        check("state", 32'(state), 32'(m_st));
    endtask

    task automatic step(input logic v, input logic [1:0] b, input logic r);
        bn_valid = v; bn = b; relock = r;
        @(negedge clock);
        check_outputs();
    endtask

    task automatic press_code(input logic [7:0] c);
        for (int i = 0; i < int'(CODE_LEN); i++) step(1'b1, c[2*i +: 2], 1'b0);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0: return door_open;
            1: return led_wrong;
            default: return locked_out;
        endcase
    endfunction

    task automatic count_high(input int sel, input bit noise, output int n);
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!pick(sel)) return;
            n++;
            if (noise) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else step(1'b0, 2'd0, 1'b0);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 1200; k++) begin
            if (m_st == 0) return;
            step(1'b0, 2'd0, 1'b0);
        end
        check("wait_idle", 32'(state), 32'd0);
    endtask

    task automatic enter_code(input logic [7:0] c);
        for (int i = 0; i < int'(CODE_LEN); i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 2'd0, 1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            step(1'b1, c[2*i +: 2], 1'b0);
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        check("rst_leds", 32'({door_open, led_right, led_wrong, buzzer, locked_out}), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_tries", 32'(tries), 32'd0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        clear_n = 1'b1;
    endtask

    int n;

    initial begin
        @(negedge clock);
        check_outputs();
        do_reset();

        // Correct code opens for OPEN_CYC cycles
        press_code(8'hE4);
        step(1'b0, 2'd0, 1'b0);
        check("open_state", 32'(state), 32'd3);
        check("open_tries", 32'(tries), 32'd0);
        count_high(0, 0, n);
        check("open_len", 32'(n), 32'(OPEN_CYC));

        // Wrong code then recovery
        press_code(8'hA4);
        step(1'b0, 2'd0, 1'b0);
        check("wrong_tries", 32'(tries), 32'd1);
        count_high(1, 0, n);
        check("wrong_len", 32'(n), 32'(BUZZ_CYC));
        press_code(8'hE4);
        step(1'b0, 2'd0, 1'b0);
        check("recover_state", 32'(state), 32'd3);
        check("recover_tries", 32'(tries), 32'd0);
        wait_idle();

        // Lockout after MAX_TRIES wrong codes, with presses ignored during lockout
        for (int t = 1; t <= int'(MAX_TRIES); t++) begin
            press_code(8'hA4);
            step(1'b0, 2'd0, 1'b0);
            if (t < int'(MAX_TRIES)) begin
                check("lock_tries", 32'(tries), 32'(t));
                wait_idle();
            end
        end
        check("lock_state", 32'(state), 32'd5);
        count_high(2, 1, n);
        check("lock_len", 32'(n), 32'(LOCKOUT_CYC));
        check("unlock_state", 32'(state), 32'd0);
        check("unlock_tries", 32'(tries), 32'd0);

        // Early relock on the tenth open cycle; relock in idle does nothing
        press_code(8'hE4);
        step(1'b0, 2'd0, 1'b0);
        repeat (9) step(1'b0, 2'd0, 1'b0);
        check("pre_relock_door", 32'(door_open), 32'd1);
        step(1'b0, 2'd0, 1'b1);
        check("relock_door", 32'(door_open), 32'd0);
        check("relock_state", 32'(state), 32'd0);
        step(1'b0, 2'd0, 1'b1);
        check("idle_relock", 32'(state), 32'd0);

        // Reset mid-entry, then the correct code still opens
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        check("mid_entry", 32'(state), 32'd1);
        do_reset();
        press_code(8'hE4);
        step(1'b0, 2'd0, 1'b0);
        check("post_rst_open", 32'(state), 32'd3);
        wait_idle();

        // Reset mid-lockout
        for (int t = 1; t <= int'(MAX_TRIES); t++) begin
            press_code(8'hA4);
            step(1'b0, 2'd0, 1'b0);
            if (t < int'(MAX_TRIES)) wait_idle();
        end
        repeat (100) step(1'b0, 2'd0, 1'b0);
        check("mid_lock", 32'(locked_out), 32'd1);
        do_reset();

        // Idle gap during entry
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd1, 1'b0);
`ifdef LOCKER_ENTRY_TIMEOUT_EN
        repeat (TIMEOUT_CYC) step(1'b0, 2'd0, 1'b0);
        check("timeout_check", 32'(state), 32'd2);
        step(1'b0, 2'd0, 1'b0);
        check("timeout_wrong", 32'(state), 32'd4);
        check("timeout_tries", 32'(tries), 32'd1);
`else
        repeat (600) step(1'b0, 2'd0, 1'b0);
        check("no_timeout", 32'(state), 32'd1);
        step(1'b1, 2'd2, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        check("late_open", 32'(state), 32'd3);
`endif
        wait_idle();

        // Randomized episodes
        for (int e = 0; e < 40; e++) begin
            case ($urandom_range(0, 4))
                0: begin wait_idle(); enter_code(sw); end
                1: begin wait_idle(); enter_code(8'($urandom)); end
                2: repeat ($urandom_range(20, 60))
                       step(1'($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
                3: sw = 8'($urandom);
                default: begin
                    wait_idle();
                    enter_code(sw);
                    repeat ($urandom_range(0, 30)) step(1'b0, 2'd0, 1'b0);
                    step(1'b0, 2'd0, 1'b1);
                end
            endcase
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/locker_access_ctrl.md
# locker_access_ctrl

Access controller for the digital locker. It collects a fixed-length button code, compares it against the switch-programmed combination, and counts failed attempts. It sequences the door-open, wrong-code and lockout phases, driving `led_right`, `led_wrong`, `buzzer` and `door_open` in place of a bare door FSM.

## Interface
- `CODE_LEN`, 4, symbols per code; each symbol is 2 bits.
- `MAX_TRIES`, 3, consecutive wrong attempts that trigger lockout (≥1).
- `OPEN_CYC`, 200, cycles `door_open` stays high.
- `BUZZ_CYC`, 50, cycles of buzzer/`led_wrong` after one wrong attempt.
- `LOCKOUT_CYC`, 1000, lockout duration in cycles.
- `TIMEOUT_CYC`, 500, maximum idle gap between presses during entry (only when the macro is defined).
- `clock  in  1`: system clock; rising edge.
- `clear_n  in  1`: asynchronous, active-low reset.
- `bn  in  2`: button symbol; sampled only when `bn_valid`=1.
- `bn_valid  in  1`: one-cycle strobe per button press; already debounced upstream.
- `sw  in  2*CODE_LEN`: stored combination; symbol i = `sw[2i+1:2i]`; symbol 0 is entered first.
- `relock  in  1`: closes the door early.
- `door_open  out  1`: door unlocked.
- `led_right  out  1`: correct-code indicator.
- `led_wrong  out  1`: wrong-code / lockout indicator.
- `buzzer  out  1`: buzzer drive.
- `locked_out  out  1`: high in LOCKOUT.
- `tries  out  $clog2(MAX_TRIES+1)`: consecutive-failure count.
- `state  out  3`: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, WRONG=4, LOCKOUT=5.
- Outputs are a Moore decode of registered state and counters. There are no combinational paths from inputs to outputs.
- **IDLE**
  - All indicators are 0.
  - On `bn_valid`: latch `sw` into the code register, set `idx`=1, set `mismatch`=(`bn`≠symbol 0), then go to ENTRY.
  - If `CODE_LEN`=1, go directly to CHECK instead.
- **ENTRY**
  - Each `bn_valid` does `mismatch |= (bn≠code[idx])` and `idx++`.
  - When `idx` reaches `CODE_LEN`, go to CHECK.
  - A `sw` change during entry has no effect; the combination was latched on the first press.
- **CHECK** (exactly one cycle)
  - `mismatch`=0: go to OPEN and clear `tries` to 0.
  - Otherwise `tries++` (saturating at `MAX_TRIES`):
    - if the new value = `MAX_TRIES`, go to LOCKOUT;
    - else go to WRONG.
- **OPEN**
  - `door_open`=`led_right`=1.
  - Leaves for IDLE after `OPEN_CYC` cycles, or on the first cycle `relock`=1, whichever comes first. If both occur in the same cycle, the result is IDLE.
- **WRONG**
  - `led_wrong`=`buzzer`=1 for exactly `BUZZ_CYC` cycles, then go to IDLE.
- **LOCKOUT**
  - `led_wrong`=`buzzer`=`locked_out`=1 for exactly `LOCKOUT_CYC` cycles.
  - Then clear `tries` to 0 and go to IDLE.
- `bn_valid` in CHECK, OPEN, WRONG or LOCKOUT is dropped, not buffered.
- `relock` outside OPEN is ignored.
- A single down-counter is shared by OPEN, WRONG, LOCKOUT and the timeout. It is loaded on state entry and sized for the largest parameter.

## Timing
- Reset (asynchronous, while `clear_n`=0):
  - state=IDLE;
  - `tries`, `idx`, `mismatch` and the timer are 0;
  - all outputs are 0 and `state`=0.
- Reset assertion mid-operation aborts immediately. Deassertion must be released synchronously to `clock` by the system.
- Latency, with the last code press sampled at edge N:
  - CHECK is visible after edge N;
  - OPEN/WRONG/LOCKOUT outputs are high after edge N+1.
- A phase of length `X_CYC` keeps its outputs high for exactly X rising edges, then IDLE.
- `relock` sampled high at edge M in OPEN: `door_open` is low after edge M.

## Configuration
- `LOCKER_ENTRY_TIMEOUT_EN`
  - Defined:
    - in ENTRY, `TIMEOUT_CYC` consecutive cycles without `bn_valid` go to CHECK with `mismatch` forced to 1, counting as a wrong attempt;
    - the timer reloads on every press.
  - Undefined: ENTRY waits indefinitely, and `TIMEOUT_CYC` is unused.

## Test plan
- **Correct code.** `sw`=8'b11_10_01_00; presses 0,1,2,3 → `door_open`=`led_right`=1 for 200 cycles starting 2 edges after the last press; `tries`=0.
- **Wrong code, then recovery.** Presses 0,1,2,2 → `led_wrong`=`buzzer`=1 for 50 cycles; `tries`=1. Then presses 0,1,2,3 → OPEN and `tries`=0.
- **Lockout.** Three wrong codes → `locked_out`=1 for 1000 cycles. Presses during lockout are ignored (state stays 5). Afterwards `tries`=0 and state=IDLE.
- **Early relock.** `relock`=1 on the 10th OPEN cycle → `door_open`=0 the next cycle; state=0. A `relock` pulse in IDLE has no effect.
- **Reset mid-operation.** `clear_n`=0 mid-ENTRY and mid-LOCKOUT → all outputs 0 immediately. After release, the correct code opens the door.
- **Entry timeout** (macro defined, `TIMEOUT_CYC`=500). Presses 0,1, then silence for 500 cycles → WRONG phase; `tries`=1. With the macro undefined, the controller stays in ENTRY.
